// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with an oversampled bit clock.
//
// The rx pin is synchronised through two flops. A falling edge on the
// synchronised line starts a frame, and the tick generator is re-phased to
// that edge. Each bit is then sampled near its centre: OVERSAMPLE/2 ticks
// into the start bit, then every OVERSAMPLE ticks after that. Good bytes are
// presented on a valid/ready output register.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   rx         asynchronous serial input, idle high
//   rx_data    received byte, meaningful while rx_valid=1
//   rx_valid   byte available, held until accepted
//   rx_ready   consumer accept (transfer on rx_valid & rx_ready)
//   busy       frame reception in progress (state != IDLE)
//   frame_err  1-clk pulse: stop bit sampled low
//   overrun    1-clk pulse: good byte dropped, output register still full
module uart_rx #(
  parameter int CLOCK      = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIVISOR    = CLOCK / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int              SW        = $clog2(OVERSAMPLE);
  localparam logic [15:0]     DIV_LAST  = 16'(DIVISOR - 1);
  localparam logic [SW-1:0]   HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]   FULL_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t        state;
  logic          rx_sync_p0;
  logic          rx_sync_p1;
  logic [15:0]   tick_cnt;
  logic [SW-1:0] samp_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          tick;
  logic          rxs;
  logic          bit_sample;

  assign rxs        = rx_sync_p1;
  assign tick       = (tick_cnt == DIV_LAST);
  assign bit_sample = (state == ST_DATA) && tick && (samp_cnt == FULL_LAST);

  // Shift register is pure data: it is only ever read after all eight
  // positions of the current frame have been written, so it needs no reset.
  always_ff @(posedge clk) begin
    if (bit_sample) begin
      shift_reg[bit_idx] <= rxs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      tick_cnt   <= '0;
      samp_cnt   <= '0;
      bit_idx    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Stage p0/p1: two-flop synchroniser on the asynchronous pin.
      rx_sync_p0 <= rx;
      rx_sync_p1 <= rx_sync_p0;

      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      tick_cnt   <= tick ? 16'd0 : tick_cnt + 16'd1;

      // Plain handshake; a delivery below on the same edge overrides this.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state    <= ST_START;
            busy     <= 1'b1;
            tick_cnt <= '0;
            samp_cnt <= '0;
          end
        end

        ST_START: begin
          if (tick) begin
            if (samp_cnt == HALF_LAST) begin
              if (!rxs) begin
                state    <= ST_DATA;
                samp_cnt <= '0;
                bit_idx  <= '0;
              end else begin
                // Line went back high before mid start bit: glitch.
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (samp_cnt == FULL_LAST) begin
              samp_cnt <= '0;
              if (bit_idx == 3'd7) begin
                state <= ST_STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (samp_cnt == FULL_LAST) begin
              samp_cnt <= '0;
              if (rxs) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                // Load when empty, or when the old byte leaves on this edge.
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shift_reg;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                state     <= ST_WAIT_HIGH;
              end
            end else begin
              samp_cnt <= samp_cnt + SW'(1);
            end
          end
        end

        ST_WAIT_HIGH: begin
          // Hold off until the line recovers so a break yields one error.
          if (rxs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Main instance runs at CLOCK=1600, BAUD=100 (16 clk per bit); two instances
// at default parameters receive frames with 5208 and 5400 clk bit periods.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_m, rst_t;
  logic       rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frame_err, overrun;

  logic       rx_a, rx_b;
  logic       rdy_t;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, busy_a, busy_b, fe_a_p, fe_b_p, ovr_a, ovr_b;

  always #5 clk = ~clk;

  uart_rx #(.CLOCK(1600), .BAUD(100), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst_m), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  uart_rx dut_a (
    .clk(clk), .rst(rst_t), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
    .rx_ready(rdy_t), .busy(busy_a), .frame_err(fe_a_p), .overrun(ovr_a)
  );

  uart_rx dut_b (
    .clk(clk), .rst(rst_t), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
    .rx_ready(rdy_t), .busy(busy_b), .frame_err(fe_b_p), .overrun(ovr_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int n_pop = 0;
  int n_unexp = 0;
  int fe_cnt = 0, ovr_cnt = 0, fe_a = 0, fe_b = 0;
  bit lat_chk = 1'b0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Main-instance frame, 16 clk per bit; rx is left at the stop level.
  task automatic send(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    fall_cyc = cyc;
    wait_clk(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clk(16);
    end
    rx = stop;
    wait_clk(16);
  endtask

  task automatic set_tol(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  task automatic send_tol(input bit sel, input int per, input logic [7:0] b);
    set_tol(sel, 1'b0);
    wait_clk(per);
    for (int i = 0; i < 8; i++) begin
      set_tol(sel, b[i]);
      wait_clk(per);
    end
    set_tol(sel, 1'b1);
    wait_clk(per);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every accepted transfer.
  always @(negedge clk) begin
    if (!rst_m) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          n_unexp++;
        end else begin
          check("xfer_data", rx_data, exp_q.pop_front());
          n_pop++;
        end
      end
      if (rx_valid && !prev_valid && lat_chk) begin
        check("latency_ok", ((cyc - fall_cyc) >= 150 && (cyc - fall_cyc) <= 158), 1);
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ovr_cnt++;
    end
    if (fe_a_p) fe_a++;
    if (fe_b_p) fe_b++;
    prev_valid <= rx_valid;
  end

  int fe0, ovr0, pop0;

  initial begin
    rx = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    rx_ready = 1'b0; rdy_t = 1'b0;
    rst_m = 1'b1; rst_t = 1'b1;
    wait_clk(3);
    rst_m = 1'b0; rst_t = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);

    fork
      begin
        // Reset in the middle of a frame, with a byte already held.
        exp_q.push_back(8'hC3);
        send(8'hC3, 1'b1);
        check("hold_valid", rx_valid, 1);
        check("hold_data", rx_data, 8'hC3);
        rx = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 3; i++) begin
          rx = 1'b1;
          wait_clk(16);
        end
        rx = 1'b1;
        wait_clk(8);
        check("midframe_busy", busy, 1);
        rst_m = 1'b1;
        wait_clk(1);
        rst_m = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_valid", rx_valid, 0);
        check("midrst_data", rx_data, 0);
        exp_q.delete();
        rx = 1'b1;
        wait_clk(40);

        fe0 = fe_cnt;
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1);
        check("post_rst_valid", rx_valid, 1);
        check("post_rst_data", rx_data, 8'h5A);
        check("post_rst_ferr", fe_cnt - fe0, 0);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        wait_clk(20);

        // Back-to-back frames, consumer always ready.
        rx_ready = 1'b1;
        ovr0 = ovr_cnt; pop0 = n_pop;
        lat_chk = 1'b1;
        exp_q.push_back(8'h00); send(8'h00, 1'b1);
        exp_q.push_back(8'hFF); send(8'hFF, 1'b1);
        exp_q.push_back(8'hA5); send(8'hA5, 1'b1);
        wait_clk(5);
        lat_chk = 1'b0;
        check("b2b_count", n_pop - pop0, 3);
        check("b2b_ovr", ovr_cnt - ovr0, 0);

        // False start: 4 clk low pulse.
        fe0 = fe_cnt; pop0 = n_pop;
        rx = 1'b0;
        wait_clk(4);
        rx = 1'b1;
        wait_clk(30);
        check("false_busy", busy, 0);
        check("false_valid", rx_valid, 0);
        check("false_ferr", fe_cnt - fe0, 0);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1);
        wait_clk(5);
        check("after_false_cnt", n_pop - pop0, 1);

        // Framing error followed by a break.
        fe0 = fe_cnt; pop0 = n_pop;
        send(8'h81, 1'b0);
        wait_clk(100);
        check("break_busy", busy, 1);
        rx = 1'b1;
        wait_clk(20);
        check("break_ferr", fe_cnt - fe0, 1);
        check("break_nodata", n_pop - pop0, 0);
        check("break_idle", busy, 0);
        exp_q.push_back(8'h42);
        send(8'h42, 1'b1);
        wait_clk(5);
        check("after_break_cnt", n_pop - pop0, 1);

        // Overrun, then a transfer on the very edge a new byte loads.
        rx_ready = 1'b0;
        ovr0 = ovr_cnt;
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        wait_clk(5);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        check("ovr_pulse", ovr_cnt - ovr0, 1);
        ovr0 = ovr_cnt; pop0 = n_pop;
        exp_q.push_back(8'h33);
        fork
          send(8'h33, 1'b1);
          begin
            wait_clk(154);
            check("simul_pre_valid", rx_valid, 1);
            rx_ready = 1'b1;
            wait_clk(1);
            rx_ready = 1'b0;
            check("simul_valid", rx_valid, 1);
            check("simul_data", rx_data, 8'h33);
          end
        join
        check("simul_ovr", ovr_cnt - ovr0, 0);
        check("simul_pop", n_pop - pop0, 1);
        rx_ready = 1'b1;
        wait_clk(2);
        check("drain_valid", rx_valid, 0);
      end
      begin
        send_tol(1'b0, 5208, 8'h96);
        wait_clk(10);
        check("tol5208_valid", valid_a, 1);
        check("tol5208_data", data_a, 8'h96);
        check("tol5208_ferr", fe_a, 0);
      end
      begin
        send_tol(1'b1, 5400, 8'h96);
        wait_clk(10);
        check("tol5400_valid", valid_b, 1);
        check("tol5400_data", data_b, 8'h96);
        check("tol5400_ferr", fe_b, 0);
      end
    join

    check("sb_empty", exp_q.size(), 0);
    check("sb_unexpected", n_unexp, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Generates its own oversampled sample tick from the system clock and samples each bit at its centre.
- Presents each received byte on a valid/ready output port.
- Receive-side counterpart of the UART transmit path; sits between the external RX pin and the byte consumer.

Parameters:
- CLOCK, 50000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit period; must be even and >= 4.
- DIVISOR, CLOCK/(BAUD*OVERSAMPLE), clocks per sample tick (integer truncation; 325 at defaults); must satisfy 1 <= DIVISOR <= 65535.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts; transfer occurs on a clk edge where rx_valid=1 and rx_ready=1.
- busy  output  1  high while a frame is being received (state != IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: good byte dropped because the output register was still full.

Behaviour:
- Reset (synchronous, active-high, one clk edge):
  - rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0.
  - State=IDLE; tick and bit counters=0.
  - Both synchronizer flops=1.
  - rst overrides any frame in progress; a partial byte is discarded.
- Input synchronizer:
  - rx passes through 2 flops to give rxs.
  - The state machine sees only rxs; latency is 2 clocks.
- Tick generator:
  - 16-bit counter; emits tick for 1 clk when the counter reaches DIVISOR-1, then wraps to 0.
  - Counter is cleared on the IDLE->START transition, so ticks are phase-aligned to the detected start edge.
- State IDLE (busy=0):
  - rxs==0 -> go to START; clear tick counter and sample counter.
- State START:
  - Count ticks. At tick OVERSAMPLE/2 (mid start bit): rxs==0 -> go to DATA with sample counter=0 and bit index=0.
  - rxs==1 at that point is a glitch/false start -> return to IDLE; no output and no error pulse.
- State DATA:
  - Every OVERSAMPLE ticks, sample rxs into shift register position bit index (LSB first).
  - After bit index 7 is sampled -> go to STOP.
- State STOP:
  - After OVERSAMPLE ticks, sample rxs.
  - rxs==1 -> byte good; deliver as below; go to IDLE.
  - rxs==0 -> frame_err pulses for 1 clk; byte discarded; go to WAIT_HIGH.
- State WAIT_HIGH:
  - Stay until rxs==1, then go to IDLE.
  - A break condition (line held low) therefore produces exactly one frame_err and no repeated frames.
- Delivery on a good stop sample, same edge as the STOP exit:
  - rx_valid==0: load rx_data, set rx_valid=1.
  - rx_valid==1 and rx_ready==1 on this edge: old byte transfers; new byte loads; rx_valid stays 1.
  - rx_valid==1 and rx_ready==0: new byte dropped; overrun pulses 1 clk; rx_data and rx_valid unchanged.
- Handshake:
  - On a clk edge with rx_valid=1 and rx_ready=1 and no concurrent delivery, rx_valid clears.
  - rx_data holds its last value after clearing.
  - rx_ready while rx_valid=0 is ignored.
- End-to-end latency:
  - rx_valid rises 2 clocks (synchronizer) plus 1 clock after the mid-stop-bit tick.
  - That tick is about 9.5 bit periods after the falling edge of the start bit.

Test Plan:
- Bench setting: CLOCK=1600, BAUD=100, OVERSAMPLE=16, so DIVISOR=1 and 1 bit = 16 clk.
- Reset check: assert rst mid-frame (during DATA bit 3) -> next cycle busy=0, rx_valid=0, rx_data=0. A full frame 0x5A sent after reset release -> rx_data=0x5A, rx_valid=1, frame_err=0.
- Back-to-back frames: 0x00, 0xFF, 0xA5 with rx_ready tied 1 -> three deliveries in order, with rx_data 0x00, 0xFF, 0xA5. overrun never pulses; rx_valid rises ~154 clk after each start edge.
- False start: rx low for 4 clk then high -> state returns to IDLE, busy drops, no rx_valid, no frame_err. A following frame 0x3C is received correctly.
- Framing/break: frame 0x81 with the stop bit low, then line held low for 100 clk -> exactly one frame_err pulse and no rx_valid. After rx returns high, frame 0x42 is received normally.
- Overrun and simultaneous accept:
  - rx_ready=0; send 0x11 then 0x22 -> rx_data stays 0x11; overrun pulses once when 0x22 completes.
  - Then with rx_ready=1 pulsed exactly on the delivery edge of frame 0x33 -> rx_data=0x33, rx_valid stays 1, no overrun.
- Baud tolerance: defaults (DIVISOR=325), transmitter bit period of 5208 clk (true 9600 baud) and of 5400 clk (+3.8%) -> byte 0x96 received correctly in both cases, frame_err=0.
